dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the CPU data-memory port: accepts the `cpu`'s `mem_read`/`mem_write` requests on `data_addr`/`data_in` and returns `data_out` with a configurable wait-state latency and a one-cycle `mem_ready` completion pulse. It holds a byte array that is read and written little-endian: word at A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}. It sits between `cpu` and the data side of the memory subsystem, and gives the testbench a way to test the CPU's load/store stall logic.

## Interface
- `DEPTH_BYTES`, 256: storage size in bytes; power of two, ≥ 8.
- `LATENCY`, 2: wait cycles between request acceptance and completion; 0–15.
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: synchronous active-low reset. One clock; reset is synchronous and active-low.
- `data_addr` input 32: byte address from CPU.
- `data_in` input 32: store data from CPU.
- `mem_read` input 1: load request, level.
- `mem_write` input 1: store request, level.
- `data_out` output 32: load result.
- `mem_ready` output 1: completion pulse, one cycle.
- `mem_err` output 1: error pulse, coincident with `mem_ready`.
- `mem_size` input 2: only with `DMEM_SUBWORD_EN`. 00 = byte, 01 = half, 10 = word, 11 = reserved, treated as an error.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit down-counter `wcnt` drives WAIT.
- **IDLE:** when exactly one of `mem_read`/`mem_write` is high at a clock edge, the block latches addr, data, op and size.
  - Next state is WAIT with `wcnt = LATENCY-1` if `LATENCY > 0`; otherwise RESP.
  - If both are high, the block latches an error request and goes through the same path. No storage change.
- **WAIT:** `wcnt` decrements each cycle. At `wcnt == 0` the next state is RESP.
- **RESP:** `mem_ready = 1` for this cycle only; next state is IDLE.
  - Store: bytes are committed at the rising edge that ends RESP.
  - Load: `data_out` is updated at the edge entering RESP and is valid during RESP.
- Address use: index = latched addr mod `DEPTH_BYTES`. Upper bits are ignored, so accesses wrap; they are not an error.
- Misalignment: word access requires addr[1:0] == 0; half access requires addr[0] == 0.
  - A misaligned or both-ops request completes with `mem_err = 1` and `mem_ready = 1`.
  - No bytes are written and `data_out` is driven to 0.
- `data_out` holds its last value outside RESP. It changes only on load completion or error.
- The CPU holds its request stable until it sees `mem_ready`. Request inputs during WAIT and RESP are ignored.
- A request still asserted in the IDLE cycle after RESP is accepted as a new request (back-to-back).
- Storage is not cleared by reset; contents are undefined until written.

## Timing
- Reset (`rst_n = 0` at an edge): state = IDLE, `wcnt` = 0, `mem_ready` = 0, `mem_err` = 0, `data_out` = 0.
- Reset in WAIT or RESP aborts the access. Any pending store is dropped, including one in RESP at the reset edge, because reset has priority over the write.
- Latency: request sampled at edge N, `mem_ready` high during cycle N+LATENCY+1.
- Throughput: one access per LATENCY+2 cycles.
- `mem_ready` and `mem_err` are registered outputs; no combinational path from inputs.

## Configuration
- `DMEM_SUBWORD_EN` defined:
  - Port `mem_size` exists.
  - Byte and half stores write only the addressed 1 or 2 bytes, taken from `data_in[7:0]` or `data_in[15:0]`.
  - Byte and half loads return the addressed bytes zero-extended in `data_out`. The CPU handles sign extension.
- `DMEM_SUBWORD_EN` undefined:
  - No `mem_size` port; every access is a word access.
  - Alignment is checked on addr[1:0] only.

## Test plan
- **Word store/load, LATENCY = 2:** write 0x11223344 at 0x04, then read 0x04.
  - `mem_ready` 3 cycles after each request.
  - `data_out` = 0x11223344; bytes 4..7 = 44, 33, 22, 11.
- **Back-to-back reads, LATENCY = 0:** hold `mem_read` at 0x00 then 0x08 (pre-written 5 and 9).
  - `mem_ready` on alternate cycles.
  - `data_out` = 5, then 9.
- **Errors:** word read at 0x06 gives `mem_err` = `mem_ready` = 1, `data_out` = 0. Read and write both high at 0x10 gives `mem_err`, and the word at 0x10 is unchanged.
- **Wrap, DEPTH_BYTES = 256:** store 0xCAFEF00D at 0x104, then load 0x04 → `data_out` = 0xCAFEF00D.
- **Reset mid-store, LATENCY = 3:** store 0xDEADBEEF to 0x0C (old value 7) and assert `rst_n = 0` in the second WAIT cycle.
  - Outputs go to 0 and state returns to IDLE.
  - A subsequent load of 0x0C returns 7.
- **`DMEM_SUBWORD_EN`:** with 0x11223344 at 0x00:
  - Byte store 0xAB to 0x02 → word reads 0x11AB3344.
  - Half load at 0x02 → 0x000011AB.
  - Half load at 0x01 → `mem_err`.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-memory responder with LATENCY wait states and little-endian byte storage.
// Define DMEM_SUBWORD_EN to add the mem_size port and byte/half accesses.
module dmem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
`ifdef DMEM_SUBWORD_EN
    input  logic [1:0]  mem_size,
`endif
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        mem_err
);
    localparam int         AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WCNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdat_q, wdat_d;
    logic           wr_q, wr_d;
    logic           err_q, err_d;
    logic [1:0]     size_q, size_d;
    logic [31:0]    data_out_q, data_out_d;
    logic           mem_ready_q, mem_ready_d;
    logic           mem_err_q, mem_err_d;
    logic [7:0]     mem_q [DEPTH_BYTES];

    logic [1:0]     req_size;
    logic           req_err;
    logic           accept;
    logic [31:0]    rd_word;
    logic [31:0]    rd_dat;
    logic           wr_en;
    logic           unused_addr_hi;

`ifdef DMEM_SUBWORD_EN
    assign req_size = mem_size;
`else
    assign req_size = SZ_WORD;
`endif

    // Upper address bits only alias into the array; accesses wrap.
    assign unused_addr_hi = ^data_addr[31:AW];

    assign accept  = (state_q == IDLE) && (mem_read || mem_write);
    assign req_err = (mem_read && mem_write)
                   || (req_size == 2'b11)
                   || ((req_size == SZ_WORD) && (data_addr[1:0] != 2'b00))
                   || ((req_size == SZ_HALF) && data_addr[0]);

    // Request capture; the *_d values double as "current request" for LATENCY == 0.
    always_comb begin
        addr_d = addr_q;
        wdat_d = wdat_q;
        wr_d   = wr_q;
        err_d  = err_q;
        size_d = size_q;
        if (accept) begin
            addr_d = data_addr[AW-1:0];
            wdat_d = data_in;
            wr_d   = mem_write && !mem_read;
            err_d  = req_err;
            size_d = req_size;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) state_d = RESP;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_word = {mem_q[addr_d + AW'(3)], mem_q[addr_d + AW'(2)],
                   mem_q[addr_d + AW'(1)], mem_q[addr_d]};
        case (size_d)
            SZ_BYTE: rd_dat = {24'd0, rd_word[7:0]};
            SZ_HALF: rd_dat = {16'd0, rd_word[15:0]};
            default: rd_dat = rd_word;
        endcase
    end

    always_comb begin
        mem_ready_d = (state_d == RESP);
        mem_err_d   = (state_d == RESP) && err_d;
        data_out_d  = data_out_q;
        if (state_d == RESP) begin
            if (err_d)      data_out_d = 32'd0;
            else if (!wr_d) data_out_d = rd_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            addr_q      <= '0;
            wdat_q      <= 32'd0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= SZ_WORD;
            data_out_q  <= 32'd0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            size_q      <= size_d;
            data_out_q  <= data_out_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Store commits on the edge leaving RESP; reset on that edge wins.
    assign wr_en = (state_q == RESP) && wr_q && !err_q;

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[addr_q] <= wdat_q[7:0];
            if (size_q != SZ_BYTE) mem_q[addr_q + AW'(1)] <= wdat_q[15:8];
            if (size_q == SZ_WORD) begin
                mem_q[addr_q + AW'(2)] <= wdat_q[23:16];
                mem_q[addr_q + AW'(3)] <= wdat_q[31:24];
            end
        end
    end

    assign data_out  = data_out_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level model plus directed and random accesses.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        mem_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_addr (data_addr),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
`ifdef DMEM_SUBWORD_EN
        .mem_size  (mem_size),
`endif
        .data_out  (data_out),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Reference model: byte array plus one outstanding transaction timed by cycle number.
    logic [7:0]  mmem [DEPTH];
    int          cyc = 0;
    int          resp_cyc = 0;
    bit          busy = 0;
    bit          in_resp = 0;
    logic [31:0] p_addr, p_dat;
    logic        p_wr, p_err;
    logic [1:0]  p_size;
    logic        exp_ready = 0;
    logic        exp_err = 0;
    logic [31:0] exp_data = 0;

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] w;
        w = {mmem[(a + 3) % DEPTH], mmem[(a + 2) % DEPTH], mmem[(a + 1) % DEPTH], mmem[a % DEPTH]};
        if (sz == 2'd0) return w & 32'h0000_00FF;
        if (sz == 2'd1) return w & 32'h0000_FFFF;
        return w;
    endfunction

    always @(posedge clk) begin
        logic [1:0] sz;
        int nb;
        cyc++;
        if (!rst_n) begin
            busy = 0; in_resp = 0;
            exp_ready = 0; exp_err = 0; exp_data = 0;
        end else begin
            exp_ready = 0;
            exp_err   = 0;
            if (in_resp) begin
                if (p_wr && !p_err) begin
                    nb = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
                    for (int k = 0; k < nb; k++) mmem[(p_addr + k) % DEPTH] = p_dat[8*k +: 8];
                end
                in_resp = 0;
            end else begin
                if (!busy && (mem_read || mem_write)) begin
`ifdef DMEM_SUBWORD_EN
                    sz = mem_size;
`else
                    sz = 2'd2;
`endif
                    p_addr = data_addr; p_dat = data_in; p_size = sz;
                    p_wr   = mem_write && !mem_read;
                    p_err  = (mem_read && mem_write) || (sz == 2'd3)
                          || (sz == 2'd2 && (data_addr % 4) != 0)
                          || (sz == 2'd1 && (data_addr % 2) != 0);
                    busy = 1;
                    resp_cyc = cyc + LAT;
                end
                if (busy && cyc == resp_cyc) begin
                    busy = 0; in_resp = 1;
                    exp_ready = 1; exp_err = p_err;
                    if (p_err)      exp_data = 0;
                    else if (!p_wr) exp_data = model_read(p_addr, p_size);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cyc_mem_ready", 32'(mem_ready), 32'(exp_ready));
            chk("cyc_mem_err",   32'(mem_err),   32'(exp_err));
            chk("cyc_data_out",  data_out,       exp_data);
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        mem_read = rd; mem_write = wr; data_addr = a; data_in = d; mem_size = sz;
    endtask

    // Counts edges from the sampling edge until mem_ready is seen.
    task automatic wait_ready(output int n, output logic [31:0] q, output logic e);
        n = 0; q = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                n = i; q = data_out; e = mem_err;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ready_timeout actual=none required=mem_ready within 40 cycles");
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] sz,
                             output int n, output logic [31:0] q, output logic e);
        issue(rd, wr, a, d, sz);
        wait_ready(n, q, e);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2;
        logic [31:0] q, q2;
        logic e, e2;
        logic [31:0] a, d;
        int r;

        rst_n = 0; mem_read = 0; mem_write = 0; data_addr = 0; data_in = 0; mem_size = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(mem_ready), 32'd0);
        chk("reset_err",   32'(mem_err),   32'd0);
        chk("reset_data",  data_out,       32'd0);
        rst_n = 1;

        for (int w = 0; w < DEPTH / 4; w++) do_access(0, 1, 32'(w * 4), $urandom, 2'd2, n, q, e);

        // Word store/load round trip
        do_access(0, 1, 32'h04, 32'h1122_3344, 2'd2, n, q, e);
        chk("st_latency", 32'(n), 32'd3);
        chk("st_err", 32'(e), 32'd0);
        do_access(1, 0, 32'h04, 32'h0, 2'd2, n, q, e);
        chk("ld_latency", 32'(n), 32'd3);
        chk("ld_data", q, 32'h1122_3344);
        chk("model_bytes", {mmem[4], mmem[5], mmem[6], mmem[7]}, 32'h4433_2211);

        // Back-to-back reads with the request held
        do_access(0, 1, 32'h00, 32'd5, 2'd2, n, q, e);
        do_access(0, 1, 32'h08, 32'd9, 2'd2, n, q, e);
        issue(1, 0, 32'h00, 32'h0, 2'd2);
        wait_ready(n, q, e);
        @(negedge clk);
        data_addr = 32'h08;
        wait_ready(n2, q2, e2);
        @(negedge clk);
        mem_read = 0;
        chk("b2b_first", q, 32'd5);
        chk("b2b_second", q2, 32'd9);
        chk("b2b_spacing", 32'(n2), 32'(LAT + 2));

        // Error cases
        do_access(1, 0, 32'h06, 32'h0, 2'd2, n, q, e);
        chk("misalign_err", 32'(e), 32'd1);
        chk("misalign_data", q, 32'd0);
        do_access(0, 1, 32'h10, 32'h0102_0304, 2'd2, n, q, e);
        do_access(1, 1, 32'h10, 32'hFFFF_FFFF, 2'd2, n, q, e);
        chk("both_err", 32'(e), 32'd1);
        do_access(1, 0, 32'h10, 32'h0, 2'd2, n, q, e);
        chk("both_nowrite", q, 32'h0102_0304);

        // Address wrap
        do_access(0, 1, 32'h104, 32'hCAFE_F00D, 2'd2, n, q, e);
        do_access(1, 0, 32'h04, 32'h0, 2'd2, n, q, e);
        chk("wrap_data", q, 32'hCAFE_F00D);

        // Reset during the second WAIT cycle drops the store
        do_access(0, 1, 32'h0C, 32'd7, 2'd2, n, q, e);
        issue(0, 1, 32'h0C, 32'hDEAD_BEEF, 2'd2);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 0; mem_write = 0;
        @(negedge clk);
        chk("abort_ready", 32'(mem_ready), 32'd0);
        chk("abort_data", data_out, 32'd0);
        rst_n = 1;
        do_access(1, 0, 32'h0C, 32'h0, 2'd2, n, q, e);
        chk("abort_keep", q, 32'd7);

`ifdef DMEM_SUBWORD_EN
        do_access(0, 1, 32'h00, 32'h1122_3344, 2'd2, n, q, e);
        do_access(0, 1, 32'h02, 32'h0000_00AB, 2'd0, n, q, e);
        do_access(1, 0, 32'h00, 32'h0, 2'd2, n, q, e);
        chk("sub_byte_store", q, 32'h11AB_3344);
        do_access(1, 0, 32'h02, 32'h0, 2'd1, n, q, e);
        chk("sub_half_load", q, 32'h0000_11AB);
        do_access(1, 0, 32'h01, 32'h0, 2'd1, n, q, e);
        chk("sub_half_err", 32'(e), 32'd1);
`endif

        // Random traffic; per-cycle compare runs against the model throughout
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            d = $urandom;
`ifdef DMEM_SUBWORD_EN
            mem_size = 2'($urandom_range(0, 3));
`endif
            if (r == 9) begin
                issue(0, 1, a, d, mem_size);
                repeat ($urandom_range(1, LAT + 1)) @(posedge clk);
                @(negedge clk);
                rst_n = 0; mem_write = 0;
                @(negedge clk);
                rst_n = 1;
            end else begin
                do_access(r <= 3 || r == 8, r >= 4, a, d, mem_size, n, q, e);
                chk("rand_latency", 32'(n), 32'(LAT + 1));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
